// File: rtl/mmcm_seq_pkg.sv
// rtl/mmcm_seq_pkg.sv - state encoding and counter sizing for mmcm_reset_sequencer
//   seq_state_t    : sequencer states
//   seq_cnt_width  : width of the shared phase counter ($clog2 of largest cycle count, plus 1)
package mmcm_seq_pkg;

  typedef enum logic [2:0] {
    RESET     = 3'd0,
    WAIT_LOCK = 3'd1,
    RELEASE   = 3'd2,
    READY_ST  = 3'd3,
    FAULT     = 3'd4,
    PWRDN     = 3'd5
  } seq_state_t;

  localparam logic [3:0] RETRY_SAT = 4'hF;

  function automatic int seq_cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sync2_ff.sv
// rtl/sync2_ff.sv - two-flop synchronizer, async active-low reset to 0
//   clk   in  destination clock
//   rst_n in  asynchronous active-low reset
//   d     in  asynchronous input
//   q     out synchronized output, lags d by two clk edges
module sync2_ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mmcm_reset_sequencer.sv
// rtl/mmcm_reset_sequencer.sv - MMCM reset/lock sequencer with lock filter, timeout and retries
//   clk          in   free-running reference clock (not an MMCM output)
//   rst_n        in   asynchronous active-low reset
//   req_rst      in   restart request; clears fault and retry count
//   req_pwrdwn   in   power down the MMCM while high
//   locked       in   MMCM LOCKED, asynchronous to clk
//   mmcm_rst     out  MMCM RST
//   mmcm_pwrdwn  out  MMCM PWRDWN
//   ready        out  clocks valid, downstream resets may release
//   fault        out  retries exhausted
//   retry_cnt    out  failed attempts in the current sequence (saturating)
module mmcm_reset_sequencer
  import mmcm_seq_pkg::*;
#(
  parameter int RST_HOLD_CYCLES     = 16,
  parameter int LOCK_FILTER_CYCLES  = 8,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int RELEASE_CYCLES      = 4,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_rst,
  input  logic       req_pwrdwn,
  input  logic       locked,
  output logic       mmcm_rst,
  output logic       mmcm_pwrdwn,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt
);

  localparam int CW = seq_cnt_width(RST_HOLD_CYCLES, LOCK_FILTER_CYCLES,
                                    LOCK_TIMEOUT_CYCLES, RELEASE_CYCLES);
  localparam int FW = $clog2(LOCK_FILTER_CYCLES) + 1;

  localparam logic [CW-1:0] HOLD_LAST    = CW'(RST_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] RELEASE_LAST = CW'(RELEASE_CYCLES - 1);
  localparam logic [FW-1:0] FILTER_LAST  = FW'(LOCK_FILTER_CYCLES - 1);
  localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRIES);

  seq_state_t    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [FW-1:0] filt, filt_n;
  logic [3:0]    retry_n, retry_inc;
  logic          lock_s;

  sync2_ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (locked),
    .q     (lock_s)
  );

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 1'b1;
    filt_n    = '0;
    retry_n   = retry_cnt;
    retry_inc = (retry_cnt == RETRY_SAT) ? retry_cnt : retry_cnt + 4'd1;

    if (req_pwrdwn) begin
      state_n = PWRDN;
      cnt_n   = '0;
    end else if (req_rst) begin
      // Held high this re-enters RESET every cycle, restarting the hold count.
      state_n = RESET;
      cnt_n   = '0;
      retry_n = '0;
    end else begin
      unique case (state)
        RESET: begin
          if (cnt == HOLD_LAST) begin
            state_n = WAIT_LOCK;
            cnt_n   = '0;
          end
        end
        WAIT_LOCK: begin
          // Lock acceptance is tested before the timeout on the same lock_s
          // sample, so a lock completing on the last timeout cycle wins.
          if (lock_s && (filt == FILTER_LAST)) begin
            state_n = RELEASE;
            cnt_n   = '0;
          end else if (cnt == TIMEOUT_LAST) begin
            retry_n = retry_inc;
            cnt_n   = '0;
            // >= also catches a count already at the limit, e.g. after a
            // power-down taken out of FAULT, which does not clear it.
            state_n = (retry_inc >= RETRY_LIMIT) ? FAULT : RESET;
          end else begin
            filt_n = lock_s ? filt + 1'b1 : '0;
          end
        end
        RELEASE: begin
          if (!lock_s) begin
            state_n = RESET;
            cnt_n   = '0;
          end else if (cnt == RELEASE_LAST) begin
            state_n = READY_ST;
            cnt_n   = '0;
            retry_n = '0;
          end
        end
        READY_ST: begin
          cnt_n = '0;
          if (!lock_s) state_n = RESET;
        end
        FAULT: begin
          cnt_n = '0;
        end
        PWRDN: begin
          cnt_n   = '0;
          state_n = RESET;
        end
        default: begin
          state_n = RESET;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RESET;
      cnt         <= '0;
      filt        <= '0;
      retry_cnt   <= '0;
      mmcm_rst    <= 1'b1;
      mmcm_pwrdwn <= 1'b0;
      ready       <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      filt        <= filt_n;
      retry_cnt   <= retry_n;
      mmcm_rst    <= (state_n == RESET) || (state_n == FAULT) || (state_n == PWRDN);
      mmcm_pwrdwn <= (state_n == PWRDN);
      ready       <= (state_n == READY_ST);
      fault       <= (state_n == FAULT);
    end
  end

endmodule

// File: tb/tb_mmcm_reset_sequencer.sv
// tb/tb_mmcm_reset_sequencer.sv - scoreboard bench for mmcm_reset_sequencer
module tb_mmcm_reset_sequencer;

  localparam int HOLD    = 4;
  localparam int FILTER  = 3;
  localparam int TIMEOUT = 20;
  localparam int REL     = 2;
  localparam int MAXR    = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_rst;
  logic       req_pwrdwn;
  logic       locked;
  logic       mmcm_rst;
  logic       mmcm_pwrdwn;
  logic       ready;
  logic       fault;
  logic [3:0] retry_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mmcm_reset_sequencer #(
    .RST_HOLD_CYCLES     (HOLD),
    .LOCK_FILTER_CYCLES  (FILTER),
    .LOCK_TIMEOUT_CYCLES (TIMEOUT),
    .RELEASE_CYCLES      (REL),
    .MAX_RETRIES         (MAXR)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_rst     (req_rst),
    .req_pwrdwn  (req_pwrdwn),
    .locked      (locked),
    .mmcm_rst    (mmcm_rst),
    .mmcm_pwrdwn (mmcm_pwrdwn),
    .ready       (ready),
    .fault       (fault),
    .retry_cnt   (retry_cnt)
  );

  // Reference model: phases timed by elapsed edges since phase entry,
  // lock filter judged from the recorded history of synchronized samples.
  typedef enum {P_RESET, P_WAIT, P_REL, P_READY, P_FAULT, P_PWRDN} phase_e;

  phase_e     ph = P_RESET;
  int         ph_start = 0;
  int         m_retry = 0;
  bit         samp[$];
  bit         ls_hist[$];
  logic [7:0] exp_q[$];
  bit         model_started = 1'b0;

  function automatic void enter(input phase_e p, input int n);
    ph       = p;
    ph_start = n + 1;
  endfunction

  function automatic logic [7:0] expect_vec();
    logic r, pw, rd, f;
    r  = (ph == P_RESET) || (ph == P_FAULT) || (ph == P_PWRDN);
    pw = (ph == P_PWRDN);
    rd = (ph == P_READY);
    f  = (ph == P_FAULT);
    return {r, pw, rd, f, 4'(m_retry)};
  endfunction

  function automatic void model_step();
    int n, e;
    bit ls, acc;
    n = samp.size();
    samp.push_back(locked === 1'b1);
    ls = (n >= 2) ? samp[n-2] : 1'b0;
    ls_hist.push_back(ls);
    e = n - ph_start;
    if (req_pwrdwn === 1'b1) begin
      enter(P_PWRDN, n);
    end else if (req_rst === 1'b1) begin
      enter(P_RESET, n);
      m_retry = 0;
    end else begin
      case (ph)
        P_RESET: if (e == HOLD - 1) enter(P_WAIT, n);
        P_WAIT: begin
          acc = (n - FILTER + 1 >= ph_start);
          if (acc) for (int k = 0; k < FILTER; k++) if (!ls_hist[n-k]) acc = 1'b0;
          if (acc) enter(P_REL, n);
          else if (e == TIMEOUT - 1) begin
            if (m_retry < 15) m_retry++;
            enter((m_retry >= MAXR) ? P_FAULT : P_RESET, n);
          end
        end
        P_REL: begin
          if (!ls) enter(P_RESET, n);
          else if (e == REL - 1) begin
            enter(P_READY, n);
            m_retry = 0;
          end
        end
        P_READY: if (!ls) enter(P_RESET, n);
        P_FAULT: ;
        P_PWRDN: enter(P_RESET, n);
        default: enter(P_RESET, n);
      endcase
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp.delete();
      ls_hist.delete();
      ph       = P_RESET;
      ph_start = 0;
      m_retry  = 0;
      exp_q.delete();
      exp_q.push_back(expect_vec());
    end else begin
      model_step();
      exp_q.push_back(expect_vec());
    end
    model_started = 1'b1;
  end

  always @(negedge clk) begin : monitor
    logic [7:0] exp_v, got_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      got_v = {mmcm_rst, mmcm_pwrdwn, ready, fault, retry_cnt};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL scoreboard t=%0t {rst,pwrdwn,ready,fault,retry} got=%b expected=%b",
                 $time, got_v, exp_v);
      end
    end else if (model_started) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty t=%0t no expected entry", $time);
    end
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      0:       return ready;
      1:       return fault;
      2:       return mmcm_rst;
      default: return mmcm_pwrdwn;
    endcase
  endfunction

  task automatic wait_sig(input string name, input int sel, input logic val,
                          input int maxc, output int took);
    took = -1;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk);
      if (pick(sel) === val) begin
        took = i;
        break;
      end
    end
    #1;
    checks++;
    if (took < 0) begin
      errors++;
      $display("FAIL %s: no event within %0d cycles", name, maxc);
    end
  endtask

  task automatic assert_rst(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_mmcm_rst"}, mmcm_rst, 1);
    check({tag, "_mmcm_pwrdwn"}, mmcm_pwrdwn, 0);
    check({tag, "_ready"}, ready, 0);
    check({tag, "_fault"}, fault, 0);
    check({tag, "_retry"}, retry_cnt, 0);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #2;
    assert_rst(tag);
    req_rst    = 1'b0;
    req_pwrdwn = 1'b0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  initial begin
    int took, cnt, run;
    bit saw_ready;
    rst_n      = 1'b0;
    req_rst    = 1'b0;
    req_pwrdwn = 1'b0;
    locked     = 1'b0;
    cyc(3);
    check("reset_mmcm_rst", mmcm_rst, 1);
    check("reset_ready", ready, 0);
    rst_n = 1'b1;

    // 1: lock 5 cycles after release -> ready after sync(2)+filter(3)+release(2)
    cyc(5);
    locked = 1'b1;
    wait_sig("s1_ready", 0, 1'b1, 40, took);
    check("s1_ready_latency", took, 2 + FILTER + REL);
    check("s1_retry", retry_cnt, 0);

    // 2: no lock -> two timeouts then FAULT; req_rst clears it
    locked = 1'b0;
    do_reset("s2_rst");
    wait_sig("s2_fault", 1, 1'b1, 120, took);
    check("s2_fault_latency", took, MAXR * (HOLD + TIMEOUT));
    check("s2_retry", retry_cnt, MAXR);
    check("s2_mmcm_rst", mmcm_rst, 1);
    cyc(10);
    check("s2_fault_held", fault, 1);
    req_rst = 1'b1;
    cyc(1);
    req_rst = 1'b0;
    check("s2_fault_cleared", fault, 0);
    check("s2_retry_cleared", retry_cnt, 0);
    check("s2_restart_rst", mmcm_rst, 1);

    // 3: two-cycle glitches never satisfy the filter; steady high is accepted
    saw_ready = 1'b0;
    for (int g = 0; g < 4; g++) begin
      locked = 1'b1;
      cyc(2);
      if (ready) saw_ready = 1'b1;
      locked = 1'b0;
      cyc(2);
      if (ready) saw_ready = 1'b1;
    end
    check("s3_no_ready_glitch", saw_ready, 0);
    locked = 1'b1;
    wait_sig("s3_ready", 0, 1'b1, 80, took);

    // 4: one-cycle lock loss in READY_ST
    locked = 1'b0;
    cyc(1);
    locked = 1'b1;
    wait_sig("s4_ready_drop", 0, 1'b0, 3, took);
    check("s4_drop_latency", took, 2);
    check("s4_reset_reentered", mmcm_rst, 1);
    wait_sig("s4_recover", 0, 1'b1, 40, took);
    check("s4_retry", retry_cnt, 0);

    // 5: power-down beats a simultaneous req_rst; then a full hold
    locked = 1'b0;
    do_reset("s5_rst");
    cyc(6);
    req_pwrdwn = 1'b1;
    req_rst    = 1'b1;
    cyc(1);
    check("s5_pwrdwn", mmcm_pwrdwn, 1);
    check("s5_mmcm_rst", mmcm_rst, 1);
    cyc(4);
    req_pwrdwn = 1'b0;
    req_rst    = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!mmcm_rst) break;
      if (!mmcm_pwrdwn) cnt++;
    end
    #1;
    check("s5_hold_cycles", cnt, HOLD);

    // 6: async reset while in RELEASE
    locked = 1'b1;
    do_reset("s6_pre");
    repeat (7) @(posedge clk);
    #2;
    check("s6_in_release_rst", mmcm_rst, 0);
    check("s6_in_release_ready", ready, 0);
    assert_rst("s6_async");
    cyc(2);
    rst_n = 1'b1;
    wait_sig("s6_recover", 0, 1'b1, 40, took);

    // Randomized traffic against the reference model
    for (int blk = 0; blk < 4; blk++) begin
      do_reset("rnd_rst");
      cnt = 0;
      while (cnt < 400) begin
        run        = $urandom_range(1, 30);
        locked     = ($urandom_range(0, 3) != 0);
        req_rst    = ($urandom_range(0, 40) == 0);
        req_pwrdwn = ($urandom_range(0, 60) == 0);
        cyc(1);
        req_rst = 1'b0;
        if ($urandom_range(0, 3) != 0) req_pwrdwn = 1'b0;
        cyc(run);
        req_pwrdwn = 1'b0;
        cnt += run + 1;
      end
    end

    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
